// File: rtl/min_sec.sv
// Seconds/minutes BCD timekeeper with a one-second prescaler, a synchronised
// minute-advance button and a once-per-hour carry pulse for the hour counter.
module min_sec #(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mplus,
  output logic [3:0] sec_10,
  output logic [3:0] sec1,
  output logic [3:0] min_10,
  output logic [3:0] min1,
  output logic       w_h,
  output logic       tick_1s
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sec10_q, sec10_d, sec1_q, sec1_d;
  logic [3:0]       min10_q, min10_d, min1_q, min1_d;
  logic             wh_q, wh_d, tick_q, tick_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             pend_q, pend_d;

  logic             wrap, edge_det, man_req, sec_carry;
  logic [3:0]       sec10_inc, sec1_inc, min10_inc, min1_inc;
  logic             sec_wrap, min_wrap;

  assign wrap      = (cnt_q == DIV_LAST);
  assign edge_det  = sync2_q & ~sync3_q;
  assign man_req   = edge_det | pend_q;
  assign sec_carry = wrap & sec_wrap;

  always_comb begin
    sec1_inc  = sec1_q + 4'd1;
    sec10_inc = sec10_q;
    sec_wrap  = 1'b0;
    if (sec1_q == 4'd9) begin
      sec1_inc = 4'd0;
      if (sec10_q == 4'd5) begin
        sec10_inc = 4'd0;
        sec_wrap  = 1'b1;
      end else begin
        sec10_inc = sec10_q + 4'd1;
      end
    end
  end

  always_comb begin
    min1_inc  = min1_q + 4'd1;
    min10_inc = min10_q;
    min_wrap  = 1'b0;
    if (min1_q == 4'd9) begin
      min1_inc = 4'd0;
      if (min10_q == 4'd5) begin
        min10_inc = 4'd0;
        min_wrap  = 1'b1;
      end else begin
        min10_inc = min10_q + 4'd1;
      end
    end
  end

  // A button edge that lands on a seconds carry is parked for one cycle.
  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    tick_d  = wrap;
    sec1_d  = sec1_q;
    sec10_d = sec10_q;
    min1_d  = min1_q;
    min10_d = min10_q;
    wh_d    = 1'b0;
    pend_d  = 1'b0;
    if (wrap) begin
      sec1_d  = sec1_inc;
      sec10_d = sec10_inc;
    end
    if (sec_carry) begin
      min1_d  = min1_inc;
      min10_d = min10_inc;
      wh_d    = min_wrap;
      pend_d  = man_req;
    end else if (man_req) begin
      min1_d  = min1_inc;
      min10_d = min10_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      sec1_q  <= 4'd0;
      sec10_q <= 4'd0;
      min1_q  <= 4'd0;
      min10_q <= 4'd0;
      wh_q    <= 1'b0;
      tick_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sec1_q  <= sec1_d;
      sec10_q <= sec10_d;
      min1_q  <= min1_d;
      min10_q <= min10_d;
      wh_q    <= wh_d;
      tick_q  <= tick_d;
      sync1_q <= mplus;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pend_q  <= pend_d;
    end
  end

  assign sec_10  = sec10_q;
  assign sec1    = sec1_q;
  assign min_10  = min10_q;
  assign min1    = min1_q;
  assign w_h     = wh_q;
  assign tick_1s = tick_q;

endmodule

// File: tb/tb_min_sec.sv
// Directed bench for min_sec with a 4-cycle second; expected values are
// hand-computed from tick counts and edge positions.
module tb_min_sec;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mplus = 1'b0;
  logic [3:0] sec_10, sec1, min_10, min1;
  logic       w_h, tick_1s;

  int n_tests = 0;
  int n_fail  = 0;
  int wh_cnt  = 0;
  int wh_bad  = 0;

  min_sec #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .mplus(mplus),
    .sec_10(sec_10), .sec1(sec1), .min_10(min_10), .min1(min1),
    .w_h(w_h), .tick_1s(tick_1s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && w_h) begin
      wh_cnt++;
      if (!tick_1s) wh_bad++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int disp();
    return {16'h0, min_10, min1, sec_10, sec1};
  endfunction

  // Returns at the negedge on which tick_1s is seen high, n times over.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!tick_1s && cyc < CLK_DIV + 2);
      if (!tick_1s) check("tick_timeout", 0, 1);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset state and first tick latency
    #12;
    check("rst_disp", disp(), 16'h0000);
    check("rst_wh", w_h, 0);
    check("rst_tick", tick_1s, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_no_tick_3", tick_1s, 0);
    @(negedge clk);
    check("t1_tick_4", tick_1s, 1);
    check("t1_sec1", disp(), 16'h0001);
    @(negedge clk);
    check("t1_tick_drop", tick_1s, 0);

    // 2: seconds rollover into minutes
    run_ticks(8);
    check("t2_9s", disp(), 16'h0009);
    run_ticks(1);
    check("t2_10s", disp(), 16'h0010);
    run_ticks(50);
    check("t2_60s", disp(), 16'h0100);
    check("t2_no_wh", wh_cnt, 0);

    // 3: hour carry
    run_ticks(3539);
    check("t3_5959", disp(), 16'h5959);
    run_ticks(1);
    check("t3_wh", w_h, 1);
    check("t3_0000", disp(), 16'h0000);
    @(negedge clk);
    check("t3_wh_drop", w_h, 0);
    check("t3_wh_cnt", wh_cnt, 1);

    // 4: held button gives one increment on the third edge, then manual wrap
    mplus = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_e2", min1, 0);
    @(negedge clk);
    check("t4_e3", min1, 1);
    repeat (17) @(negedge clk);
    mplus = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_held_once", {min_10, min1}, 8'h01);
    repeat (58) begin
      mplus = 1'b1;
      @(negedge clk);
      mplus = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("t4_preset59", disp(), 16'h5936);
    run_ticks(1);
    mplus = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_e2_59", {min_10, min1}, 8'h59);
    @(negedge clk);
    check("t4_wrap", disp(), 16'h0037);
    check("t4_no_wh", w_h, 0);
    mplus = 1'b0;
    @(negedge clk);
    check("t4_no_wh2", w_h, 0);

    // 5: button edge collides with seconds carry
    reset_pulse();
    run_ticks(59);
    check("t5_0059", disp(), 16'h0059);
    @(negedge clk);
    mplus = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_pre", disp(), 16'h0059);
    @(negedge clk);
    check("t5_carry", disp(), 16'h0100);
    check("t5_tick", tick_1s, 1);
    check("t5_no_wh", w_h, 0);
    @(negedge clk);
    check("t5_pending", disp(), 16'h0200);
    mplus = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_final", {min_10, min1}, 8'h02);

    // 6: asynchronous reset mid-count
    reset_pulse();
    run_ticks(754);
    check("t6_1234", disp(), 16'h1234);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_async_disp", disp(), 16'h0000);
    check("t6_async_tick", tick_1s, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_no_tick_3", tick_1s, 0);
    @(negedge clk);
    check("t6_tick_4", tick_1s, 1);
    check("t6_disp", disp(), 16'h0001);

    check("wh_total", wh_cnt, 1);
    check("wh_without_tick", wh_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
